// File: rtl/logip_pkg.sv
// Shared types for the pattern generator: divider width and FSM state encoding.
package logip_pkg;

   localparam int unsigned DIV_W = 24;

   typedef logic [DIV_W-1:0] div_t;

   typedef enum logic [1:0] {
      PG_IDLE,
      PG_PRIME,
      PG_RUN
   } pg_state_e;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO buffering sample words for replay.
module sample_fifo #(
   parameter int unsigned W     = 32,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [W-1:0]             din_i,
   output logic [W-1:0]             dout_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push_c;
   logic          do_pop_c;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];

   // Flush overrides both ports; the guards keep pointers sane on misuse.
   assign do_push_c = push_i && !full_o && !flush_i;
   assign do_pop_c  = pop_i && !empty_o && !flush_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push_c) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({do_push_c, do_pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; occupancy is tracked by the pointers.
   always_ff @(posedge clk_i) begin
      if (do_push_c) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/pattern_gen.sv
// Pattern generator: replays FIFO-buffered sample words onto data_o, one word per divider tick.
module pattern_gen
   import logip_pkg::*;
#(
   parameter int unsigned CHLS  = 32,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned PRIME = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [DIV_W-1:0] fdiv_i,
   input  logic             set_div_i,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic [CHLS-1:0]  smpls_i,
   input  logic             stb_i,
   output logic             rdy_o,
   output logic [CHLS-1:0]  data_o,
   output logic             stb_o,
   output logic             underrun_o
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   pg_state_e       state_q, state_d;
   div_t            div_q, div_d;
   div_t            cnt_q, cnt_d;
   logic [CHLS-1:0] data_q, data_d;
   logic            stb_q, stb_d;
   logic            underrun_q, underrun_d;

   logic             fifo_push_c;
   logic             fifo_pop_c;
   logic             fifo_flush_c;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic [CHLS-1:0]  fifo_head;
   logic             tick_c;

   sample_fifo #(
      .W     (CHLS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (fifo_flush_c),
      .push_i  (fifo_push_c),
      .pop_i   (fifo_pop_c),
      .din_i   (smpls_i),
      .dout_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign rdy_o       = !fifo_full;
   assign fifo_push_c = stb_i && !fifo_full && !clr_i;

   // Counter only runs in RUN, so the first tick always lands div cycles after entry.
   assign tick_c = (state_q == PG_RUN) && (cnt_q == '0);

   always_comb begin
      state_d      = state_q;
      div_d        = div_q;
      cnt_d        = cnt_q;
      data_d       = data_q;
      stb_d        = 1'b0;
      underrun_d   = underrun_q;
      fifo_pop_c   = 1'b0;
      fifo_flush_c = 1'b0;

      if (state_q == PG_RUN) begin
         cnt_d = tick_c ? div_q : (cnt_q - div_t'(1));
      end else begin
         cnt_d = div_q;
      end

      if (set_div_i) begin
         div_d = fdiv_i;
         cnt_d = fdiv_i;
      end

      if (clr_i) begin
         fifo_flush_c = 1'b1;
         underrun_d   = 1'b0;
         state_d      = en_i ? PG_PRIME : PG_IDLE;
      end else if (!en_i) begin
         state_d = PG_IDLE;
      end else begin
         case (state_q)
            PG_IDLE: state_d = PG_PRIME;
            PG_PRIME: begin
               if (fifo_full || (fifo_count >= CNT_W'(PRIME))) state_d = PG_RUN;
            end
            PG_RUN: begin
               if (tick_c) begin
                  if (fifo_empty) begin
                     underrun_d = 1'b1;
                     state_d    = PG_PRIME;
                  end else begin
                     fifo_pop_c = 1'b1;
                     data_d     = fifo_head;
                     stb_d      = 1'b1;
                  end
               end
            end
            default: state_d = PG_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= PG_IDLE;
         div_q      <= '0;
         cnt_q      <= '0;
         data_q     <= '0;
         stb_q      <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         cnt_q      <= cnt_d;
         data_q     <= data_d;
         stb_q      <= stb_d;
         underrun_q <= underrun_d;
      end
   end

   assign data_o     = data_q;
   assign stb_o      = stb_q;
   assign underrun_o = underrun_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Directed self-checking bench for pattern_gen: priming, divider timing, full/flush/reset cases.
module tb_pattern_gen;
   import logip_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [23:0] fdiv_i;
   logic        set_div_i;
   logic        en_i;
   logic        clr_i;
   logic [31:0] smpls_i;
   logic        stb_i;
   logic        rdy_o;
   logic [31:0] data_o;
   logic        stb_o;
   logic        underrun_o;

   int vectors    = 0;
   int miscompares = 0;

   pattern_gen #(
      .CHLS  (32),
      .DEPTH (16),
      .PRIME (8)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .fdiv_i     (fdiv_i),
      .set_div_i  (set_div_i),
      .en_i       (en_i),
      .clr_i      (clr_i),
      .smpls_i    (smpls_i),
      .stb_i      (stb_i),
      .rdy_o      (rdy_o),
      .data_o     (data_o),
      .stb_o      (stb_o),
      .underrun_o (underrun_o)
   );

   always #5 clk_i = ~clk_i;

   // One clock: inputs set before the call are sampled at this edge; outputs read 1ns after.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push_words(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         smpls_i = base + 32'(i);
         stb_i   = 1'b1;
         step();
      end
      stb_i = 1'b0;
   endtask

   task automatic load_div(input logic [23:0] d);
      fdiv_i    = d;
      set_div_i = 1'b1;
      step();
      set_div_i = 1'b0;
   endtask

   task automatic clear_idle();
      en_i  = 1'b0;
      clr_i = 1'b1;
      step();
      clr_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      step();
      step();
      rst_i = 1'b0;
      vectors++;
      if (data_o !== 32'h0 || stb_o !== 1'b0 || underrun_o !== 1'b0 || rdy_o !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_outputs got data=%h stb=%b und=%b rdy=%b exp 0/0/0/1",
                  data_o, stb_o, underrun_o, rdy_o);
      end
      vectors++;
      if (dut.state_q !== PG_IDLE || dut.fifo_count !== 5'd0) begin
         miscompares++;
         $display("FAIL reset_state got state=%0d count=%0d exp IDLE/0", dut.state_q, dut.fifo_count);
      end
   endtask

   task automatic test_prime_run();
      load_div(24'd0);
      en_i = 1'b1;
      push_words(32'h1, 8);
      step();
      vectors++;
      if (dut.state_q !== PG_RUN) begin
         miscompares++;
         $display("FAIL prime_to_run got state=%0d exp RUN", dut.state_q);
      end
      for (int k = 1; k <= 8; k++) begin
         step();
         vectors++;
         if (stb_o !== 1'b1 || data_o !== 32'(k)) begin
            miscompares++;
            $display("FAIL replay_div0 k=%0d got stb=%b data=%h exp 1/%h", k, stb_o, data_o, 32'(k));
         end
      end
      step();
      vectors++;
      if (stb_o !== 1'b0 || underrun_o !== 1'b1 || data_o !== 32'h8 || dut.state_q !== PG_PRIME) begin
         miscompares++;
         $display("FAIL underrun got stb=%b und=%b data=%h state=%0d exp 0/1/8/PRIME",
                  stb_o, underrun_o, data_o, dut.state_q);
      end
      clear_idle();
      vectors++;
      if (underrun_o !== 1'b0 || dut.state_q !== PG_IDLE) begin
         miscompares++;
         $display("FAIL clr_underrun got und=%b state=%0d exp 0/IDLE", underrun_o, dut.state_q);
      end
   endtask

   task automatic test_full_div3();
      int  pushed;
      int  popped;
      bit  tick_cyc;
      bit  exp_stb;
      load_div(24'd3);
      push_words(32'h100, 16);
      vectors++;
      if (rdy_o !== 1'b0) begin
         miscompares++;
         $display("FAIL full_rdy got %b exp 0", rdy_o);
      end
      smpls_i = 32'hDEAD;
      stb_i   = 1'b1;
      step();
      stb_i   = 1'b0;
      vectors++;
      if (dut.fifo_count !== 5'd16) begin
         miscompares++;
         $display("FAIL push_when_full count got %0d exp 16", dut.fifo_count);
      end
      pushed = 0;
      popped = 0;
      en_i   = 1'b1;
      // Ticks land on cycles 5,9,13,...; upstream pushes on ticks 9..49 (push+pop at count 15).
      for (int s = 0; s <= 114; s++) begin
         tick_cyc = (s >= 5) && (((s - 5) % 4) == 0);
         stb_i    = tick_cyc && (s >= 9) && (s <= 49);
         smpls_i  = 32'h110 + 32'(pushed);
         step();
         if (stb_i) pushed++;
         stb_i   = 1'b0;
         exp_stb = tick_cyc && (s <= 109);
         vectors++;
         if (stb_o !== exp_stb) begin
            miscompares++;
            $display("FAIL div3_stb s=%0d got %b exp %b", s, stb_o, exp_stb);
         end
         if (exp_stb) begin
            vectors++;
            if (data_o !== 32'h100 + 32'(popped)) begin
               miscompares++;
               $display("FAIL div3_data s=%0d got %h exp %h", s, data_o, 32'h100 + 32'(popped));
            end
            popped++;
         end
         if (s == 52) begin
            vectors++;
            if (underrun_o !== 1'b0 || dut.fifo_count !== 5'd15) begin
               miscompares++;
               $display("FAIL div3_steady got und=%b count=%0d exp 0/15", underrun_o, dut.fifo_count);
            end
         end
      end
      vectors++;
      if (underrun_o !== 1'b1 || dut.state_q !== PG_PRIME) begin
         miscompares++;
         $display("FAIL div3_drain got und=%b state=%0d exp 1/PRIME", underrun_o, dut.state_q);
      end
   endtask

   task automatic test_set_div();
      int  idx;
      bit  exp_stb;
      clear_idle();
      vectors++;
      if (underrun_o !== 1'b0) begin
         miscompares++;
         $display("FAIL clr_sticky got und=%b exp 0", underrun_o);
      end
      load_div(24'd1);
      push_words(32'h200, 16);
      idx  = 0;
      en_i = 1'b1;
      // div=1 ticks on 3,5,7; reload to 9 on cycle 8 moves the next tick to 18.
      for (int s = 0; s <= 19; s++) begin
         set_div_i = (s == 8);
         fdiv_i    = 24'd9;
         step();
         set_div_i = 1'b0;
         exp_stb   = (s == 3) || (s == 5) || (s == 7) || (s == 18);
         vectors++;
         if (stb_o !== exp_stb) begin
            miscompares++;
            $display("FAIL setdiv_stb s=%0d got %b exp %b", s, stb_o, exp_stb);
         end
         if (exp_stb) begin
            vectors++;
            if (data_o !== 32'h200 + 32'(idx)) begin
               miscompares++;
               $display("FAIL setdiv_data s=%0d got %h exp %h", s, data_o, 32'h200 + 32'(idx));
            end
            idx++;
         end
      end
   endtask

   task automatic test_clear_run();
      clear_idle();
      load_div(24'd0);
      push_words(32'h300, 8);
      en_i = 1'b1;
      for (int s = 0; s <= 4; s++) step();
      vectors++;
      if (dut.fifo_count !== 5'd5 || data_o !== 32'h302 || dut.state_q !== PG_RUN) begin
         miscompares++;
         $display("FAIL clr_setup got count=%0d data=%h state=%0d exp 5/302/RUN",
                  dut.fifo_count, data_o, dut.state_q);
      end
      clr_i   = 1'b1;
      stb_i   = 1'b1;
      smpls_i = 32'hBEEF;
      step();
      clr_i   = 1'b0;
      stb_i   = 1'b0;
      vectors++;
      if (dut.fifo_count !== 5'd0 || underrun_o !== 1'b0 || dut.state_q !== PG_PRIME ||
          data_o !== 32'h302 || stb_o !== 1'b0) begin
         miscompares++;
         $display("FAIL clr_run got count=%0d und=%b state=%0d data=%h stb=%b exp 0/0/PRIME/302/0",
                  dut.fifo_count, underrun_o, dut.state_q, data_o, stb_o);
      end
      step();
      vectors++;
      if (stb_o !== 1'b0 || data_o !== 32'h302) begin
         miscompares++;
         $display("FAIL clr_hold got stb=%b data=%h exp 0/302", stb_o, data_o);
      end
   endtask

   task automatic test_reset_mid_run();
      clear_idle();
      load_div(24'd2);
      push_words(32'h400, 8);
      en_i = 1'b1;
      for (int s = 0; s <= 4; s++) step();
      vectors++;
      if (stb_o !== 1'b1 || data_o !== 32'h400) begin
         miscompares++;
         $display("FAIL rst_setup got stb=%b data=%h exp 1/400", stb_o, data_o);
      end
      rst_i = 1'b1;
      for (int r = 0; r < 3; r++) begin
         step();
         vectors++;
         if (data_o !== 32'h0 || stb_o !== 1'b0 || rdy_o !== 1'b1 || dut.fifo_count !== 5'd0) begin
            miscompares++;
            $display("FAIL rst_mid r=%0d got data=%h stb=%b rdy=%b count=%0d exp 0/0/1/0",
                     r, data_o, stb_o, rdy_o, dut.fifo_count);
         end
      end
      rst_i = 1'b0;
      push_words(32'h500, 7);
      for (int s = 0; s < 5; s++) begin
         step();
         vectors++;
         if (stb_o !== 1'b0 || dut.state_q !== PG_PRIME) begin
            miscompares++;
            $display("FAIL reprime_wait s=%0d got stb=%b state=%0d exp 0/PRIME", s, stb_o, dut.state_q);
         end
      end
      push_words(32'h507, 1);
      step();
      vectors++;
      if (dut.state_q !== PG_RUN) begin
         miscompares++;
         $display("FAIL reprime_run got state=%0d exp RUN", dut.state_q);
      end
      step();
      vectors++;
      if (stb_o !== 1'b1 || data_o !== 32'h500) begin
         miscompares++;
         $display("FAIL reprime_first got stb=%b data=%h exp 1/500", stb_o, data_o);
      end
   endtask

   initial begin
      rst_i     = 1'b1;
      fdiv_i    = '0;
      set_div_i = 1'b0;
      en_i      = 1'b0;
      clr_i     = 1'b0;
      smpls_i   = '0;
      stb_i     = 1'b0;
      test_reset();
      test_prime_run();
      test_full_div3();
      test_set_div();
      test_clear_run();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
